// File: rtl/fvram_pkg.sv
// rtl/fvram_pkg.sv - shared widths, state encoding and reset values for the fast VRAM sequencer
package fvram_pkg;

  localparam int FVRAM_AW = 11;
  localparam int FVRAM_DW = 16;

  typedef enum logic [2:0] {
    IDLE,
    VREAD,
    CWR1,
    CWR2,
    CRD
  } fvram_state_t;

  localparam logic [FVRAM_AW-1:0] RST_ADDR = '0;
  localparam logic [FVRAM_DW-1:0] RST_DATA = '0;
  localparam logic                RST_NCE  = 1'b1;
  localparam logic                RST_NWE  = 1'b1;

endpackage

// File: rtl/fvram_ctrl.sv
// rtl/fvram_ctrl.sv - arbitrates video reads and CPU register-port accesses onto the 2Kx16 fast VRAM
module fvram_ctrl
  import fvram_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic                CLK_24M,
  input  logic                nRESET,
  input  logic [FVRAM_DW-1:0] CPU_DIN,
  input  logic                CPU_ADDR_WE,
  input  logic                CPU_MOD_WE,
  input  logic                CPU_DATA_WE,
  output logic [FVRAM_DW-1:0] CPU_DOUT,
  output logic                CPU_BUSY,
  input  logic                VID_REQ,
  input  logic [FVRAM_AW-1:0] VID_ADDR,
  output logic                VID_ACK,
  output logic [FVRAM_DW-1:0] VID_DATA,
  output logic [FVRAM_AW-1:0] FVRAM_ADDR,
  inout  wire  [FVRAM_DW-1:0] FVRAM_DATA,
  output logic                nFVRAM_CE,
  output logic                nFVRAM_OE,
  output logic                nFVRAM_WE
);

  localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

  fvram_state_t        state_q, state_d;
  logic [FVRAM_AW-1:0] ptr_q, ptr_d, mod_q, mod_d, waddr_q, waddr_d;
  logic [FVRAM_DW-1:0] wdata_q, wdata_d;
  logic                wpend_q, wpend_d, pf_pend_q, pf_pend_d;
  logic                reload_q, reload_d;
  logic [1:0]          starve_q, starve_d;
  logic [FVRAM_AW-1:0] addr_q, addr_d;
  logic                nce_q, nce_d, nwe_q, nwe_d, drive_q, drive_d;
  logic [FVRAM_DW-1:0] dout_q, dout_d, vid_data_q, vid_data_d;
  logic                vid_ack_q, vid_ack_d, busy_q, busy_d;

  logic [FVRAM_AW-1:0] ptr_ld;
  logic                wr_acc, cpu_pend;

  always_comb begin
    ptr_ld   = CPU_ADDR_WE ? CPU_DIN[FVRAM_AW-1:0] : ptr_q;
    wr_acc   = CPU_DATA_WE && !wpend_q;
    cpu_pend = wpend_q || pf_pend_q;

    state_d    = state_q;
    ptr_d      = ptr_ld;
    mod_d      = CPU_MOD_WE ? CPU_DIN[FVRAM_AW-1:0] : mod_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wpend_d    = wpend_q;
    pf_pend_d  = pf_pend_q || CPU_ADDR_WE;
    reload_d   = reload_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    nce_d      = 1'b1;
    nwe_d      = 1'b1;
    drive_d    = 1'b0;
    dout_d     = dout_q;
    vid_ack_d  = 1'b0;
    vid_data_d = vid_data_q;

    // The address load lands first, so a same-cycle write targets the new pointer.
    if (wr_acc) begin
      waddr_d  = ptr_ld;
      wdata_d  = CPU_DIN;
      wpend_d  = 1'b1;
      reload_d = 1'b0;
    end else if (wpend_q && CPU_ADDR_WE) begin
      reload_d = 1'b1;
    end

    // Pin values are registered from the state being entered, so they are glitch-free.
    case (state_q)
      IDLE: begin
        if (VID_REQ && (!cpu_pend || (starve_q < STARVE_LIM))) begin
          state_d = VREAD;
          if (cpu_pend) starve_d = starve_q + 2'd1;
          addr_d  = VID_ADDR;
          nce_d   = 1'b0;
        end else if (wpend_q) begin
          state_d  = CWR1;
          starve_d = 2'd0;
          addr_d   = waddr_q;
          nce_d    = 1'b0;
          nwe_d    = 1'b0;
          drive_d  = 1'b1;
        end else if (pf_pend_q) begin
          state_d  = CRD;
          starve_d = 2'd0;
          addr_d   = ptr_ld;
          nce_d    = 1'b0;
        end
      end
      VREAD: begin
        state_d    = IDLE;
        vid_ack_d  = 1'b1;
        vid_data_d = FVRAM_DATA;
      end
      CWR1: begin
        state_d = CWR2;
        drive_d = 1'b1;
      end
      CWR2: begin
        state_d   = IDLE;
        wpend_d   = 1'b0;
        reload_d  = 1'b0;
        pf_pend_d = 1'b1;
        if (!(reload_q || CPU_ADDR_WE)) ptr_d = waddr_q + mod_d;
      end
      CRD: begin
        state_d = IDLE;
        // A pointer reload during the read makes the captured word stale.
        if (!CPU_ADDR_WE) begin
          dout_d    = FVRAM_DATA;
          pf_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = wpend_d || pf_pend_d || (state_d inside {CWR1, CWR2, CRD});
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      mod_q      <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wpend_q    <= 1'b0;
      pf_pend_q  <= 1'b0;
      reload_q   <= 1'b0;
      starve_q   <= 2'd0;
      addr_q     <= RST_ADDR;
      nce_q      <= RST_NCE;
      nwe_q      <= RST_NWE;
      drive_q    <= 1'b0;
      dout_q     <= RST_DATA;
      vid_ack_q  <= 1'b0;
      vid_data_q <= RST_DATA;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mod_q      <= mod_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wpend_q    <= wpend_d;
      pf_pend_q  <= pf_pend_d;
      reload_q   <= reload_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      nce_q      <= nce_d;
      nwe_q      <= nwe_d;
      drive_q    <= drive_d;
      dout_q     <= dout_d;
      vid_ack_q  <= vid_ack_d;
      vid_data_q <= vid_data_d;
      busy_q     <= busy_d;
    end
  end

  assign FVRAM_DATA = drive_q ? wdata_q : {FVRAM_DW{1'bz}};
  assign FVRAM_ADDR = addr_q;
  assign nFVRAM_CE  = nce_q;
  assign nFVRAM_WE  = nwe_q;
  assign nFVRAM_OE  = 1'b0;
  assign CPU_DOUT   = dout_q;
  assign CPU_BUSY   = busy_q;
  assign VID_ACK    = vid_ack_q;
  assign VID_DATA   = vid_data_q;

endmodule

// File: tb/tb_fvram_ctrl.sv
// tb/tb_fvram_ctrl.sv - scoreboard bench for fvram_ctrl with two 2048x8 SRAM models
module tb_fvram_ctrl;

  typedef struct {
    string       name;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_din;
  logic        addr_we, mod_we, data_we, vid_req;
  logic [10:0] vid_addr;
  logic [15:0] cpu_dout, vid_data;
  logic        cpu_busy, vid_ack;
  logic [10:0] fv_addr;
  wire  [15:0] fv_data;
  logic        n_ce, n_oe, n_we;

  logic [7:0]  mem_hi [2048];
  logic [7:0]  mem_lo [2048];

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t vid_q[$];
  exp_t cpu_q[$];
  logic prev_busy;

  always #21 clk = ~clk;

  fvram_ctrl #(.STARVE_MAX(3)) dut (
    .CLK_24M     (clk),
    .nRESET      (rst_n),
    .CPU_DIN     (cpu_din),
    .CPU_ADDR_WE (addr_we),
    .CPU_MOD_WE  (mod_we),
    .CPU_DATA_WE (data_we),
    .CPU_DOUT    (cpu_dout),
    .CPU_BUSY    (cpu_busy),
    .VID_REQ     (vid_req),
    .VID_ADDR    (vid_addr),
    .VID_ACK     (vid_ack),
    .VID_DATA    (vid_data),
    .FVRAM_ADDR  (fv_addr),
    .FVRAM_DATA  (fv_data),
    .nFVRAM_CE   (n_ce),
    .nFVRAM_OE   (n_oe),
    .nFVRAM_WE   (n_we)
  );

  // Upper and lower byte chips share address and strobes.
  assign fv_data = (!n_ce && n_we && !n_oe) ? {mem_hi[fv_addr], mem_lo[fv_addr]} : 16'bz;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem_hi[i] = 8'h05 ^ 8'(i >> 8) ^ 8'hA0;
      mem_lo[i] = 8'(i) ^ 8'hC3;
    end
    forever begin
      @(posedge clk);
      if (!n_ce && !n_we) begin
        mem_hi[fv_addr] = fv_data[15:8];
        mem_lo[fv_addr] = fv_data[7:0];
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input int a);
    return {mem_hi[a], mem_lo[a]};
  endfunction

  task automatic strobe(input logic a, input logic m, input logic d, input logic [15:0] din);
    cpu_din = din;
    addr_we = a;
    mod_we  = m;
    data_we = d;
    @(negedge clk);
    addr_we = 1'b0;
    mod_we  = 1'b0;
    data_we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (cpu_busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, {15'd0, cpu_busy}, 16'h0000);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: video reads pop on VID_ACK, prefetches pop when CPU_BUSY falls.
  initial begin
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
      end else begin
        if (vid_ack) begin
          if (vid_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL vid_unexpected: actual=%h required=no ack", vid_data);
          end else begin
            e = vid_q.pop_front();
            check(e.name, vid_data, e.val);
          end
        end
        if (prev_busy && !cpu_busy) begin
          if (cpu_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL cpu_unexpected: actual=%h required=no prefetch", cpu_dout);
          end else begin
            e = cpu_q.pop_front();
            check(e.name, cpu_dout, e.val);
          end
        end
        prev_busy = cpu_busy;
      end
    end
  end

  initial begin
    int n, acks, pre;
    bit done;
    rst_n    = 1'b1;
    cpu_din  = '0;
    addr_we  = 1'b0;
    mod_we   = 1'b0;
    data_we  = 1'b0;
    vid_req  = 1'b0;
    vid_addr = '0;
    #5 rst_n = 1'b0;

    @(negedge clk);
    check("rst_addr", {5'd0, fv_addr}, 16'h0000);
    check("rst_nce", {15'd0, n_ce}, 16'h0001);
    check("rst_nwe", {15'd0, n_we}, 16'h0001);
    check("rst_noe", {15'd0, n_oe}, 16'h0000);
    check("rst_dout", cpu_dout, 16'h0000);
    check("rst_busy", {15'd0, cpu_busy}, 16'h0000);
    check("rst_vid_ack", {15'd0, vid_ack}, 16'h0000);
    check("rst_vid_data", vid_data, 16'h0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Pointer load triggers a prefetch of 0x123.
    cpu_q.push_back('{"pf_123", 16'hA4E0});
    strobe(1, 0, 0, 16'h0123);
    wait_idle("pf_123");

    // Modulo 1, pointer at top of memory, two writes wrap the pointer.
    strobe(0, 1, 0, 16'h0001);
    cpu_q.push_back('{"pf_7ff", 16'hA23C});
    strobe(1, 0, 0, 16'h07FF);
    wait_idle("pf_7ff");
    cpu_q.push_back('{"pf_000", 16'hA5C3});
    strobe(0, 0, 1, 16'hBEEF);
    wait_idle("wr_beef");
    cpu_q.push_back('{"pf_001", 16'hA5C2});
    strobe(0, 0, 1, 16'h1234);
    wait_idle("wr_1234");
    check("mem_7ff", mem_rd(11'h7FF), 16'hBEEF);
    check("mem_000", mem_rd(11'h000), 16'h1234);

    // Single video read latency.
    vid_q.push_back('{"vid_050", 16'hA593});
    vid_addr = 11'h050;
    vid_req  = 1'b1;
    n = 0;
    done = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
      if (vid_ack) done = 1;
    end
    vid_req = 1'b0;
    check("vid_latency", 16'(n), 16'd2);
    repeat (2) @(negedge clk);

    // Continuous video with a queued CPU write.
    for (int i = 0; i < 6; i++) vid_q.push_back('{"vid_starve", 16'hA593});
    cpu_q.push_back('{"pf_002", 16'hA5C1});
    strobe(0, 0, 1, 16'h5555);
    vid_req = 1'b1;
    acks = 0;
    pre  = -1;
    done = 0;
    n    = 0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
      if (vid_ack) acks++;
      if (!n_we && pre < 0) pre = acks;
      if (pre >= 0 && acks == pre + 3) begin
        vid_req = 1'b0;
        done = 1;
      end
    end
    vid_req = 1'b0;
    check("starve_pre_acks", 16'(pre), 16'd3);
    check("starve_post_acks", 16'(acks - pre), 16'd3);
    wait_idle("starve");
    check("mem_001", mem_rd(11'h001), 16'h5555);

    // Same-cycle address and data strobes, then a dropped second write.
    cpu_q.push_back('{"pf_201", 16'hA7C2});
    cpu_din = 16'h0200;
    addr_we = 1'b1;
    data_we = 1'b1;
    @(negedge clk);
    addr_we = 1'b0;
    cpu_din = 16'hDEAD;
    @(negedge clk);
    data_we = 1'b0;
    wait_idle("same_cycle");
    check("mem_200", mem_rd(11'h200), 16'h0200);
    check("mem_201", mem_rd(11'h201), 16'hA7C2);

    // Reset during CWR1.
    strobe(0, 0, 1, 16'h7777);
    n = 0;
    while (n_we && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("cwr1_reached", {15'd0, n_we}, 16'h0000);
    rst_n = 1'b0;
    #1;
    check("rst_mid_nwe", {15'd0, n_we}, 16'h0001);
    check("rst_mid_nce", {15'd0, n_ce}, 16'h0001);
    @(negedge clk);
    check("rst2_addr", {5'd0, fv_addr}, 16'h0000);
    check("rst2_dout", cpu_dout, 16'h0000);
    check("rst2_busy", {15'd0, cpu_busy}, 16'h0000);
    check("rst2_vid_data", vid_data, 16'h0000);
    check("rst2_noe", {15'd0, n_oe}, 16'h0000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("write_lost", mem_rd(11'h201), 16'hA7C2);
    check("post_rst_busy", {15'd0, cpu_busy}, 16'h0000);

    check("sb_vid_drained", 16'(vid_q.size()), 16'd0);
    check("sb_cpu_drained", 16'(cpu_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fvram_ctrl.md
# fvram_ctrl

Access sequencer for the 2K×16 fast VRAM formed by the upper- and lower-byte 35 ns SRAMs. It arbitrates between the video fetch pipeline and the 68k-side VRAM register port (address, modulo, read/write) and drives the shared SRAM address, strobe and 16-bit data pins. Video reads have priority, with an anti-starvation rule for the CPU. After every address change or write, it prefetches the word at the current pointer so CPU reads return immediately.

## Interface
Parameters:
- STARVE_MAX, 3: maximum consecutive video grants while a CPU access is pending.

Ports:
- CLK_24M  in  1  system clock; the only clock.
- nRESET  in  1  asynchronous, active-low reset.
- CPU_DIN  in  16  CPU write data.
- CPU_ADDR_WE  in  1  1-cycle strobe: load pointer with CPU_DIN[10:0].
- CPU_MOD_WE  in  1  1-cycle strobe: load modulo with CPU_DIN[10:0].
- CPU_DATA_WE  in  1  1-cycle strobe: queue write of CPU_DIN at pointer.
- CPU_DOUT  out  16  prefetched word at pointer.
- CPU_BUSY  out  1  a write or prefetch is pending or in progress.
- VID_REQ  in  1  video read request; held until VID_ACK.
- VID_ADDR  in  11  video read address.
- VID_ACK  out  1  1-cycle pulse; VID_DATA valid.
- VID_DATA  out  16  video read data.
- FVRAM_ADDR  out  11  SRAM address.
- FVRAM_DATA  inout  16  SRAM data; [15:8] upper chip, [7:0] lower chip.
- nFVRAM_CE  out  1  chip enable, both chips.
- nFVRAM_OE  out  1  output enable; constant 0. nWE dominates.
- nFVRAM_WE  out  1  write enable, both chips.

## Operation
Registers:
- ptr[10:0], mod[10:0].
- One-entry write buffer: wdata, waddr, wpend.
- pf_pend: prefetch pending.
- starve counter: 2 bits.

CPU strobes:
- CPU_ADDR_WE: ptr←DIN[10:0]; pf_pend←1.
- CPU_MOD_WE: mod←DIN[10:0].
- CPU_DATA_WE when wpend=0: waddr←ptr (after any same-cycle ADDR_WE); wdata←DIN; wpend←1.
- CPU_DATA_WE when wpend=1: dropped; no state change.
- Same-cycle priority: the address load applies first, so the data write targets the new address. A same-cycle modulo load applies to this write's increment.
- Write completion: ptr←(waddr+mod) mod 2048, unless ptr was reloaded during the write, in which case the reloaded value is kept. Then pf_pend←1.
- CPU_BUSY = wpend | pf_pend | (state≠IDLE and state is not VREAD).

FSM states: IDLE, VREAD, CWR1, CWR2, CRD.

Decisions in IDLE, evaluated each cycle:
- If VID_REQ=1 and (no CPU pending or starve<STARVE_MAX): go to VREAD; starve++ if a CPU access is pending.
- Else if wpend=1: go to CWR1; starve←0.
- Else if pf_pend=1: go to CRD; starve←0.

State behaviour:
- VREAD: ADDR=VID_ADDR, nCE=0. At the next edge capture the data bus into VID_DATA; VID_ACK=1 in the following cycle. Return to IDLE.
- CWR1: ADDR=waddr, DATA=wdata driven, nCE=0, nWE=0.
- CWR2: ADDR and DATA held, nCE=1, nWE=1. At exit: wpend←0, update ptr. Return to IDLE.
- CRD: ADDR=ptr, nCE=0. Capture into CPU_DOUT; pf_pend←0. Return to IDLE.
- If ptr is reloaded during CRD, the captured data is discarded and pf_pend stays 1.
- FVRAM_DATA is high-Z in every state except CWR1 and CWR2.

## Timing
- Read latency: VID_REQ sampled at edge 0 → ADDR driven in cycle 0 → data captured at edge 1 (41.6 ns > 35 ns access) → VID_ACK high in cycle 1. Minimum video spacing is 2 cycles, because IDLE is entered between grants.
- A CPU write occupies 2 cycles. The prefetch read follows no earlier than 1 IDLE cycle later.
- All outputs are registered, so the SRAM pins are glitch-free.
- Reset values: FVRAM_ADDR=0, nFVRAM_CE=1, nFVRAM_WE=1, nFVRAM_OE=0, FVRAM_DATA=Z, CPU_DOUT=0, CPU_BUSY=0, VID_ACK=0, VID_DATA=0, ptr=0, mod=0, wpend=0, pf_pend=0, starve=0, state=IDLE.
- Reset asserted mid-write: nWE returns to 1 immediately (asynchronous) and the queued write is lost.

## Structure
- Package fvram_pkg holds:
  - FVRAM_AW=11, FVRAM_DW=16.
  - The state enum fvram_state_t.
  - The reset constants.
- Single FSM module, no sub-module.
- Benches instantiate this block with two 2048×8 fast-VRAM models sharing address and strobes.

## Test plan
- Reset, then ADDR_WE 0x123 → CRD occurs; CPU_DOUT = preloaded word at 0x123; CPU_BUSY clears.
- MOD=1, ADDR=0x7FF, write 0xBEEF, then write 0x1234 → SRAM[0x7FF]=0xBEEF, SRAM[0x000]=0x1234; ptr wraps to 0x001.
- VID_REQ held continuously with a CPU write pending → exactly 3 VID_ACKs, then CWR1/CWR2, then video resumes.
- VID_REQ with VID_ADDR=0x050 → VID_ACK 2 edges after the request, with VID_DATA = SRAM[0x050].
- ADDR_WE and DATA_WE in the same cycle (DIN=0x0200) → the write lands at 0x200. A second DATA_WE while wpend=1 is dropped, and the SRAM is unchanged.
- nRESET pulled low during CWR1 → nFVRAM_WE=1 and the bus goes Z within the same cycle; all outputs return to their reset values.
